// File: rtl/tt_serial_pkg.sv
// Shared types and helpers for the serial transmitter.
// State encoding, line levels and counter width helper.
package tt_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tt_bit_timer.sv
// Bit timer: counts CLKS_PER_BIT cycles per serial bit.
// Ports: clk, rst_n, load (restart count), en (count), tick (last cycle).
module tt_bit_timer
  import tt_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // With one clock per bit LAST is 0, so every enabled cycle ticks
  // and the count never moves off zero.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tt_serial_tx.sv
// Serial transmitter: start, DATA_W bits LSB first, even parity, stops.
// Ports: clk, rst_n, data, send in; tx (line), busy, done (pulse) out.
module tt_serial_tx
  import tt_serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              send,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BW = cnt_w(DATA_W + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic              parity;
  logic [BW-1:0]     bit_cnt;
  logic              accept;
  logic              tick;

  assign accept = (state == IDLE) && send;

  tt_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .en   (state != IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= IDLE_LVL;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      parity  <= 1'b0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (send) begin
            shreg   <= data;
            parity  <= ^data;
            bit_cnt <= '0;
            tx      <= START_LVL;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity;
                state <= PARITY;
              end else begin
                tx    <= IDLE_LVL;
                state <= STOP;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx      <= IDLE_LVL;
            bit_cnt <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            // bit_cnt now counts stop bits already sent.
            if (bit_cnt == LAST_STOP) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_serial_tx.sv
// Randomized bench for tt_serial_tx in three configurations.
// Expected line levels come from a frame model, not the RTL.
module tb_tt_serial_tx;

  logic clk;
  logic rst_n;

  logic       send0, send1, send2;
  logic [7:0] data0, data1;
  logic [0:0] data2;
  logic       tx0, busy0, done0;
  logic       tx1, busy1, done1;
  logic       tx2, busy2, done2;

  int n_chk;
  int n_fail;

  tt_serial_tx #(
    .DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data(data0), .send(send0),
    .tx(tx0), .busy(busy0), .done(done0)
  );

  tt_serial_tx #(
    .DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data(data1), .send(send1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  tt_serial_tx #(
    .DATA_W(1), .CLKS_PER_BIT(1), .PARITY_EN(0), .STOP_BITS(2)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data(data2), .send(send2),
    .tx(tx2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input int w, output int dw, output int c,
                     output int par, output int sb);
    case (w)
      0:       begin dw = 8; c = 4; par = 0; sb = 1; end
      1:       begin dw = 8; c = 4; par = 1; sb = 1; end
      default: begin dw = 1; c = 1; par = 0; sb = 2; end
    endcase
  endtask

  task automatic drive(input int w, input logic s, input logic [7:0] d);
    case (w)
      0:       begin send0 = s; data0 = d; end
      1:       begin send1 = s; data1 = d; end
      default: begin send2 = s; data2 = d[0]; end
    endcase
  endtask

  function automatic logic [2:0] outs(input int w);
    case (w)
      0:       return {tx0, busy0, done0};
      1:       return {tx1, busy1, done1};
      default: return {tx2, busy2, done2};
    endcase
  endfunction

  // Line level for frame bit i: start, data LSB first,
  // even parity over the data, then stop bits.
  function automatic logic exp_bit(input int v, input int dw,
                                   input int par, input int i);
    int ones;
    if (i == 0) return 1'b0;
    if (i <= dw) return 1'((v >> (i - 1)) % 2);
    if (par != 0 && i == dw + 1) begin
      ones = 0;
      for (int b = 0; b < dw; b++) ones += (v >> b) % 2;
      return 1'(ones % 2);
    end
    return 1'b1;
  endfunction

  // Send nf frames on DUT w. Frames 0 and 1 go back-to-back with
  // data d0, d1; later frames are random, with random idle gaps.
  // Call at a negedge with the DUT idle.
  task automatic run(input int w, input int nf,
                     input logic [7:0] d0, input logic [7:0] d1);
    int dw, c, par, sb, len, gap, mask, v;
    logic [2:0] o;
    cfg(w, dw, c, par, sb);
    len  = (1 + dw + par + sb) * c;
    mask = (1 << dw) - 1;
    v = int'(d0) & mask;
    drive(w, 1'b1, 8'(v));
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        o = outs(w);
        check($sformatf("w%0d f%0d k%0d tx", w, f, k), 32'(o[2]),
              32'(exp_bit(v, dw, par, k / c)));
        check($sformatf("w%0d f%0d k%0d busy", w, f, k), 32'(o[1]), 1);
        check($sformatf("w%0d f%0d k%0d done", w, f, k), 32'(o[0]), 0);
        drive(w, 1'($urandom_range(0, 1)), 8'($urandom));
      end
      @(negedge clk);
      o = outs(w);
      check($sformatf("w%0d f%0d end tx", w, f), 32'(o[2]), 1);
      check($sformatf("w%0d f%0d end busy", w, f), 32'(o[1]), 0);
      check($sformatf("w%0d f%0d end done", w, f), 32'(o[0]), 1);
      if (f + 1 < nf) begin
        if (f > 0 && $urandom_range(0, 1) == 1) begin
          drive(w, 1'b0, 8'($urandom));
          gap = $urandom_range(1, 3);
          for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            o = outs(w);
            check($sformatf("w%0d gap%0d", w, f), 32'(o), 32'(3'b100));
          end
        end
        v = (f == 0) ? int'(d1) : int'($urandom_range(0, 255));
        v = v & mask;
        drive(w, 1'b1, 8'(v));
      end else begin
        drive(w, 1'b0, 8'h00);
      end
    end
  endtask

  initial begin
    logic [2:0] o;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);

    #12;
    for (int w = 0; w < 3; w++)
      check($sformatf("w%0d reset", w), 32'(outs(w)), 32'(3'b100));

    @(negedge clk);
    rst_n = 1'b1;

    // Abort a frame with reset during data bit 3.
    drive(0, 1'b1, 8'hA5);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      check($sformatf("rst pre k%0d tx", k), 32'(tx0),
            32'(exp_bit(32'hA5, 8, 0, k / 4)));
      drive(0, 1'b0, 8'($urandom));
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst async tx", 32'(tx0), 1);
    check("rst async busy", 32'(busy0), 0);
    check("rst async done", 32'(done0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      o = outs(0);
      check($sformatf("rst idle %0d", i), 32'(o), 32'(3'b100));
    end

    run(0, 3, 8'hA5, 8'h00);
    run(0, 6, 8'h55, 8'hFF);
    run(1, 6, 8'h07, 8'h03);
    run(2, 8, 8'h01, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
